// File: rtl/pl_mem_pkg.sv
// Shared memory-responder definitions: access-size codes, responder FSM states,
// byte-lane mask helper. Used by the D-mem responder and future I-mem/bus responders.
package pl_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Size code 11 behaves as a word access.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << lo;
      SIZE_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = lo[0];
      default:   misaligned = |lo;
    endcase
  endfunction

endpackage

// File: rtl/pl_load_extend.sv
// Load lane select and sign/zero extension; low address bits beyond the access size are ignored.
module pl_load_extend
  import pl_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  lo,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: data = {{24{~is_unsigned & b[7]}}, b};
      SIZE_HALF: data = {{16{~is_unsigned & h[15]}}, h};
      default:   data = word;
    endcase
  end

endmodule

// File: rtl/pl_dm_responder.sv
// M-stage data-memory responder: one outstanding access, LATENCY wait states, one-cycle response.
// Optional macro MISALIGN_CHECK_EN flags misaligned half/word accesses via rsp_err.
module pl_dm_responder
  import pl_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall_o
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t              state, state_n;
  logic [CW-1:0]       cnt;
  logic                l_we, l_uns;
  logic [1:0]          l_size;
  logic [ADDR_W+1:0]   l_addr;
  logic [31:0]         l_wdata;

  logic [31:0]         mem [0:DEPTH-1];
  logic [ADDR_W-1:0]   idx;
  logic [1:0]          lo;
  logic [3:0]          mask;
  logic [31:0]         wrep, rd_word, ld_data;
  logic                do_access, mis, wr_en;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign idx       = l_addr[ADDR_W+1:2];
  assign lo        = l_addr[1:0];
  assign mask      = lane_mask(l_size, lo);
  assign do_access = (state == BUSY) && (cnt == '0);
  assign wr_en     = do_access & l_we & ~mis;
  assign rd_word   = mem[idx];

`ifdef MISALIGN_CHECK_EN
  assign mis = misaligned(l_size, lo);
`else
  assign mis = 1'b0;
`endif

  // Replicate store data across lanes so the lane mask alone picks the bytes.
  always_comb begin
    case (l_size)
      SIZE_BYTE: wrep = {4{l_wdata[7:0]}};
      SIZE_HALF: wrep = {2{l_wdata[15:0]}};
      default:   wrep = l_wdata;
    endcase
  end

  pl_load_extend u_ext (
    .word        (rd_word),
    .size        (l_size),
    .is_unsigned (l_uns),
    .lo          (lo),
    .data        (ld_data)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = BUSY;
      BUSY:    if (cnt == '0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      l_we      <= 1'b0;
      l_uns     <= 1'b0;
      l_size    <= '0;
      l_addr    <= '0;
      l_wdata   <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        l_we    <= req_we;
        l_uns   <= req_unsigned;
        l_size  <= req_size;
        l_addr  <= req_addr[ADDR_W+1:0];
        l_wdata <= req_wdata;
        cnt     <= CW'(LATENCY - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (do_access) rsp_rdata <= (l_we | mis) ? '0 : ld_data;
    end
  end

`ifdef MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rsp_err <= 1'b0;
    else if (do_access) rsp_err <= mis;
  end
`else
  assign rsp_err = 1'b0;
`endif

  // Array is deliberately not reset; an aborted store never reaches this write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mask[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign stall_o   = req_valid & ~rsp_valid;

endmodule
